// File: rtl/count_ctrl_pkg.sv
// Shared constants for the stopwatch sequencer: state encoding and default data width.
package count_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] STOP = 2'b10;
  localparam logic [1:0] LAP  = 2'b11;

endpackage

// File: rtl/count_ctrl_edge_detect.sv
// Rising-edge detector for a synchronous button level.
// History resets high so a button held through reset gives no event.
module edge_detect
  import count_ctrl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic event_o
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d  = level;
    event_o = level & ~prev_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= prev_d;
  end

endmodule

// File: rtl/count_ctrl.sv
// Stopwatch sequencer: turns start/stop, lap and clear buttons into counter
// enable/clear, a live-or-frozen display register and a sticky wrap flag.
//
// state | meaning
// IDLE  | counter stopped after reset or clear, display live
// RUN   | counter enabled, display live
// STOP  | counter paused, display live, lap ignored
// LAP   | counter enabled, display frozen at the lap value
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_stop,
  input  logic             lap,
  input  logic             clear,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [WIDTH-1:0] display,
  output logic [1:0]       state_o,
  output logic             overflow
);

  logic ss_evt, lap_evt, clr_evt;

  logic [1:0]       state_q, state_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_clr_q, cnt_clr_d;
  logic [WIDTH-1:0] display_q, display_d;
  logic [WIDTH-1:0] count_prev_q, count_prev_d;
  logic             overflow_q, overflow_d;

  edge_detect u_ed_ss  (.clock(clock), .reset(reset), .level(start_stop), .event_o(ss_evt));
  edge_detect u_ed_lap (.clock(clock), .reset(reset), .level(lap),        .event_o(lap_evt));
  edge_detect u_ed_clr (.clock(clock), .reset(reset), .level(clear),      .event_o(clr_evt));

  always_comb begin
    state_d = state_q;
    if (clr_evt) begin
      state_d = IDLE;
    end else if (ss_evt) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = STOP;
        LAP:     state_d = STOP;
        STOP:    state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (lap_evt) begin
      case (state_q)
        RUN:     state_d = LAP;
        LAP:     state_d = RUN;
        default: state_d = state_q;
      endcase
    end

    cnt_en_d  = (state_d == RUN) || (state_d == LAP);
    cnt_clr_d = clr_evt;

    // Only a stay in LAP freezes; entering LAP captures like a live update.
    if (clr_evt)
      display_d = '0;
    else if ((state_q == LAP) && (state_d == LAP))
      display_d = display_q;
    else
      display_d = count;

    count_prev_d = count;

    // Gating with cnt_en_q keeps a clear-induced drop to zero from flagging.
    overflow_d = overflow_q;
    if (clr_evt)
      overflow_d = 1'b0;
    else if ((count_prev_q == {WIDTH{1'b1}}) && (count == '0) && cnt_en_q)
      overflow_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      display_q    <= '0;
      count_prev_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_en_q     <= cnt_en_d;
      cnt_clr_q    <= cnt_clr_d;
      display_q    <= display_d;
      count_prev_q <= count_prev_d;
      overflow_q   <= overflow_d;
    end
  end

  assign cnt_en   = cnt_en_q;
  assign cnt_clr  = cnt_clr_q;
  assign display  = display_q;
  assign state_o  = state_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl; the bench drives count directly as a stand-in counter.
module tb_count_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_stop, lap, clear;
  logic [7:0] count;
  logic       cnt_en, cnt_clr, overflow;
  logic [7:0] display;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  count_ctrl #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .count(count), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .display(display),
    .state_o(state_o), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b1; lap = 1'b0; clear = 1'b0; count = 8'd0;
    #12;
    check("rst_state", state_o, 2'b00);
    check("rst_en", cnt_en, 1'b0);
    check("rst_clr", cnt_clr, 1'b0);
    check("rst_disp", display, 8'd0);
    check("rst_ovf", overflow, 1'b0);

    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_state", state_o, 2'b00);
      check("held_en", cnt_en, 1'b0);
    end
    start_stop = 1'b0; tick();
    start_stop = 1'b1; tick();
    check("go_state", state_o, 2'b01);
    check("go_en", cnt_en, 1'b1);
    start_stop = 1'b0;

    for (int v = 5; v <= 8; v++) begin
      count = 8'(v); tick();
      check("run_disp", display, 32'(v));
    end
    count = 8'd9; lap = 1'b1; tick();
    check("lap_state", state_o, 2'b11);
    check("lap_disp", display, 8'd9);
    lap = 1'b0;
    for (int v = 10; v <= 12; v++) begin
      count = 8'(v); tick();
      check("lap_hold", display, 8'd9);
      check("lap_en", cnt_en, 1'b1);
    end
    count = 8'd13; lap = 1'b1; tick();
    check("unlap_state", state_o, 2'b01);
    check("unlap_disp", display, 8'd13);
    lap = 1'b0; count = 8'd14; tick();
    check("track_disp", display, 8'd14);

    start_stop = 1'b1; lap = 1'b1; tick();
    check("prio_state", state_o, 2'b10);
    check("prio_en", cnt_en, 1'b0);
    start_stop = 1'b0; lap = 1'b0; tick();
    lap = 1'b1; tick();
    check("stop_lap", state_o, 2'b10);
    lap = 1'b0;

    count = 8'd42; tick();
    check("stop_disp", display, 8'd42);
    clear = 1'b1; tick();
    check("clr_state", state_o, 2'b00);
    check("clr_pulse", cnt_clr, 1'b1);
    check("clr_disp", display, 8'd0);
    check("clr_ovf", overflow, 1'b0);
    clear = 1'b0; tick();
    check("clr_one", cnt_clr, 1'b0);

    start_stop = 1'b1; tick();
    check("run2_state", state_o, 2'b01);
    start_stop = 1'b0;
    count = 8'd254; tick();
    count = 8'd255; tick();
    check("pre_wrap", overflow, 1'b0);
    count = 8'd0; tick();
    check("wrap", overflow, 1'b1);
    count = 8'd1;
    start_stop = 1'b1; tick();
    check("ovf_stop", overflow, 1'b1);
    start_stop = 1'b0; tick();
    start_stop = 1'b1; tick();
    check("ovf_run", overflow, 1'b1);
    check("ovf_run_st", state_o, 2'b01);
    start_stop = 1'b0;
    clear = 1'b1; tick();
    check("ovf_clr", overflow, 1'b0);
    clear = 1'b0;
    count = 8'd255; tick();
    count = 8'd0; tick();
    check("clr_nowrap", overflow, 1'b0);

    start_stop = 1'b1; tick();
    start_stop = 1'b0;
    count = 8'd77; lap = 1'b1; tick();
    check("lap2_state", state_o, 2'b11);
    lap = 1'b0; count = 8'd80; tick();
    check("lap2_hold", display, 8'd77);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("arst_state", state_o, 2'b00);
    check("arst_en", cnt_en, 1'b0);
    check("arst_disp", display, 8'd0);
    check("arst_clr", cnt_clr, 1'b0);
    check("arst_ovf", overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
